// File: rtl/pixel_top.sv
// pixel_top: 2x2 pixel sensor frame capture with a single-slope ADC readout.
// Sequence per frame: ERASE -> EXPOSE -> CONVERT (256-step shared ramp) -> READ (4 beats).
// Optional build macro PIXEL_TOP_TEST_PATTERN_EN: READ drives 8'hA0 + pix_addr
// instead of the converted codes, with identical timing.
module pixel_top #(
  parameter int         ERASE_CYCLES  = 5,
  parameter int         EXPOSE_CYCLES = 255,
  parameter logic [7:0] INTENSITY0    = 8'd64,
  parameter logic [7:0] INTENSITY1    = 8'd128,
  parameter logic [7:0] INTENSITY2    = 8'd192,
  parameter logic [7:0] INTENSITY3    = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] state,
  output logic       busy,
  output logic [7:0] pix_data,
  output logic [1:0] pix_addr,
  output logic       pix_valid,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [15:0]       cnt_reg;     // cycle counter within the current phase
  logic              last_cycle;  // current cycle is the final one of its phase
  logic              done_reg;
  logic [7:0]        ramp;        // shared ADC ramp, reuses the phase counter during CONVERT
  logic [3:0][7:0]   codes;

  assign ramp = cnt_reg[7:0];

  // Next-state logic: each busy phase lasts a fixed number of cycles.
  always_comb begin
    state_next = state_reg;
    last_cycle = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_ERASE;
      end
      S_ERASE: begin
        last_cycle = (cnt_reg == 16'(ERASE_CYCLES - 1));
        if (last_cycle) state_next = S_EXPOSE;
      end
      S_EXPOSE: begin
        last_cycle = (cnt_reg == 16'(EXPOSE_CYCLES - 1));
        if (last_cycle) state_next = S_CONVERT;
      end
      S_CONVERT: begin
        last_cycle = (cnt_reg == 16'd255);
        if (last_cycle) state_next = S_READ;
      end
      S_READ: begin
        last_cycle = (cnt_reg == 16'd3);
        if (last_cycle) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register; reset overrides any transition, including mid-frame aborts.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Phase counter restarts at zero on every phase boundary and while idle.
  always_ff @(posedge clk) begin
    if (reset || state_reg == S_IDLE || last_cycle) cnt_reg <= 16'd0;
    else                                            cnt_reg <= cnt_reg + 16'd1;
  end

  // done pulses in the first idle cycle following the final READ beat.
  always_ff @(posedge clk) begin
    if (reset) done_reg <= 1'b0;
    else       done_reg <= (state_reg == S_READ) && last_cycle;
  end

  // Per-pixel light accumulator and single-slope ADC latch.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pix
      localparam logic [7:0] INC = (gi == 0) ? INTENSITY0 :
                                   (gi == 1) ? INTENSITY1 :
                                   (gi == 2) ? INTENSITY2 : INTENSITY3;
      logic [15:0] acc_reg;
      logic [7:0]  code_reg;

      // Clear during ERASE, integrate during EXPOSE, latch ramp on match during CONVERT.
      always_ff @(posedge clk) begin
        if (reset || state_reg == S_ERASE) begin
          acc_reg  <= 16'd0;
          code_reg <= 8'd0;
        end else begin
          if (state_reg == S_EXPOSE) acc_reg <= acc_reg + {8'd0, INC};
          if (state_reg == S_CONVERT && ramp == acc_reg[15:8]) code_reg <= ramp;
        end
      end

      assign codes[gi] = code_reg;
    end
  endgenerate

  assign state     = state_reg;
  assign busy      = (state_reg != S_IDLE);
  assign pix_valid = (state_reg == S_READ);
  assign pix_addr  = pix_valid ? cnt_reg[1:0] : 2'd0;
  assign done      = done_reg;

`ifdef PIXEL_TOP_TEST_PATTERN_EN
  assign pix_data  = pix_valid ? (8'hA0 + {6'd0, pix_addr}) : 8'd0;
`else
  assign pix_data  = pix_valid ? codes[cnt_reg[1:0]] : 8'd0;
`endif

endmodule

// File: tb/tb_pixel_top.sv
// Testbench for pixel_top: directed scenarios plus random start/reset traffic,
// checked every cycle against a timeline model of the frame.
module tb_pixel_top;

  localparam int E    = 5;
  localparam int X    = 255;
  localparam int C    = 256;
  localparam int LAST = E + X + C + 4;   // cycle index of the final READ beat

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] state;
  logic       busy;
  logic [7:0] pix_data;
  logic [1:0] pix_addr;
  logic       pix_valid;
  logic       done;

  int checks = 0;
  int errors = 0;

  int unsigned intens [4] = '{64, 128, 192, 255};
  int unsigned exp_code [4];

  // Model: whether a frame is in flight, how many cycles since its start edge,
  // and whether the current cycle is the done cycle.
  bit m_active = 1'b0;
  int m_t      = 0;
  bit m_done   = 1'b0;

  pixel_top dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .state     (state),
    .busy      (busy),
    .pix_data  (pix_data),
    .pix_addr  (pix_addr),
    .pix_valid (pix_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_t      = 0;
    end else if (m_active) begin
      m_done = 1'b0;
      if (m_t == LAST) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_t = m_t + 1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_active = 1'b1;
        m_t      = 1;
      end
    end
  endtask

  task automatic check_outputs();
    int e_state, e_addr, e_data, e_valid;
    e_state = 0; e_addr = 0; e_data = 0; e_valid = 0;
    if (m_active) begin
      if (m_t <= E)            e_state = 1;
      else if (m_t <= E + X)   e_state = 2;
      else if (m_t <= E + X + C) e_state = 3;
      else begin
        e_state = 4;
        e_valid = 1;
        e_addr  = m_t - (E + X + C + 1);
`ifdef PIXEL_TOP_TEST_PATTERN_EN
        e_data  = 'hA0 + e_addr;
`else
        e_data  = exp_code[e_addr];
`endif
      end
    end
    check("state",     32'(state),     32'(e_state));
    check("busy",      32'(busy),      32'(m_active));
    check("pix_valid", 32'(pix_valid), 32'(e_valid));
    check("pix_addr",  32'(pix_addr),  32'(e_addr));
    check("pix_data",  32'(pix_data),  32'(e_data));
    check("done",      32'(done),      32'(m_done && !m_active));
    if (pix_valid) $display("beat  addr=%0d data=0x%02h", pix_addr, pix_data);
    if (done)      $display("frame done at %0t", $time);
  endtask

  task automatic cycle(input logic r, input logic s);
    reset = r;
    start = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit fired;
    for (int k = 0; k < 4; k++) exp_code[k] = (intens[k] * X) >> 8;

    @(negedge clk);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    // Single frame from a one-cycle start pulse.
    cycle(1'b0, 1'b1);
    repeat (530) cycle(1'b0, 1'b0);

    // Held start plus extra pulses in EXPOSE, CONVERT and READ are all ignored.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    for (int i = 4; i <= 530; i++)
      cycle(1'b0, (i == 100 || i == 101 || i == 400 || i == 519));

    // Abort mid-EXPOSE, then a clean frame.
    cycle(1'b0, 1'b1);
    repeat (249) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (530) cycle(1'b0, 1'b0);

    // Start and reset together: reset wins.
    cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);

    // Start issued during the done cycle launches the next frame back to back.
    cycle(1'b0, 1'b1);
    fired = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (m_done && !fired) begin
        fired = 1'b1;
        cycle(1'b0, 1'b1);
      end else begin
        cycle(1'b0, 1'b0);
      end
    end
    check("b2b_fired", 32'(fired), 32'd1);
    repeat (540) cycle(1'b0, 1'b0);

    // Random traffic: sparse starts, rare resets.
    for (int i = 0; i < 12000; i++)
      cycle($urandom_range(0, 2999) == 0, $urandom_range(0, 99) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_top.md
PIXEL_TOP -- requirements
Module: pixel_top

Interface
REQ-001 Parameter ERASE_CYCLES, default 5: number of cycles spent in ERASE.
REQ-002 Parameter EXPOSE_CYCLES, default 255: number of cycles spent in EXPOSE; legal range 1..255.
REQ-003 Parameters INTENSITY0..INTENSITY3, defaults 64/128/192/255: 8-bit per-cycle light increment of pixels 0..3 (row-major 2x2 array).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to capture one frame.
REQ-007 state  output  3  FSM state: IDLE=0, ERASE=1, EXPOSE=2, CONVERT=3, READ=4.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 pix_data  output  8  converted pixel code during READ, else 0.
REQ-010 pix_addr  output  2  pixel index {row,col} during READ, else 0.
REQ-011 pix_valid  output  1  high for each READ cycle.
REQ-012 done  output  1  one-cycle pulse on the first IDLE cycle after READ.

Function
REQ-013 IDLE: start sampled high at a rising edge moves the FSM to ERASE; start is ignored in every other state.
REQ-014 ERASE: exactly ERASE_CYCLES cycles; clears all four 16-bit accumulators and 8-bit latched codes.
REQ-015 EXPOSE: exactly EXPOSE_CYCLES cycles; each cycle, accumulator k += INTENSITYk (16-bit, no overflow possible at EXPOSE_CYCLES<=255).
REQ-016 Pixel value k = accumulator k bits [15:8], frozen at EXPOSE exit.
REQ-017 CONVERT: exactly 256 cycles; shared 8-bit ramp counts 0..255, one step per cycle; pixel k latches the ramp value in the cycle where ramp equals its value (single-slope ADC); the latched code therefore equals the value.
REQ-018 READ: exactly 4 cycles, pix_addr 0,1,2,3 in order, pix_data = latched code of that pixel, pix_valid=1.
REQ-019 After READ: IDLE with done=1 for one cycle; a start in that cycle is accepted.
REQ-020 Frame latency at defaults: start edge to first pix_valid = 5+255+256 = 516 cycles; READ spans cycles 517..520 after the start edge.
REQ-021 A start held high for multiple cycles starts one frame only; no new frame before returning to IDLE.

Reset
REQ-022 Reset sampled high: state=IDLE; busy, pix_data, pix_addr, pix_valid, done=0; counters, ramp, accumulators, codes cleared.
REQ-023 Reset has priority over start and over every FSM transition, including mid-EXPOSE/CONVERT/READ abort; no done pulse after an abort.
REQ-024 After reset release the block waits in IDLE for a new start.

Configuration
REQ-025 Macro PIXEL_TOP_TEST_PATTERN_EN: when defined, READ outputs pix_data = 8'hA0 + pix_addr instead of the latched code (timing unchanged); when undefined, latched codes are output.

Verification
REQ-026 Reset 1 cycle, start pulse -> after 516 cycles, four pix_valid cycles with pix_addr 0..3, pix_data 63,127,191,254; done pulse next cycle.
REQ-027 Start pulsed again during EXPOSE and CONVERT -> ignored; frame timing and data identical to REQ-026.
REQ-028 Start, then reset 250 cycles later (mid-EXPOSE) -> state=IDLE next cycle, busy=0, no pix_valid, no done; subsequent start yields a normal frame with codes 63,127,191,254.
REQ-029 Start and reset high in the same cycle -> remains IDLE, busy=0.
REQ-030 Start asserted in done cycle -> second frame begins immediately, identical data.
REQ-031 PIXEL_TOP_TEST_PATTERN_EN defined -> READ data A0,A1,A2,A3 at the same cycles as REQ-026.
